// File: rtl/int_sequencer.sv
// Prioritised, maskable interrupt sequencer: edge-latched requests are arbitrated in IDLE,
// then driven through a stall / stack-push / vector-jump entry sequence until reti.
module int_sequencer #(
  parameter int          NIRQ        = 8,
  parameter logic [15:0] VEC_BASE    = 16'h00F8,
  parameter int          CALL_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NIRQ-1:0] interrupts,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  input  logic            reti,
  output logic [15:0]     Addr,
  output logic            Call,
  output logic            INTjmp,
  output logic            intSTOP,
  output logic            active,
  output logic [2:0]      irq_idx,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STOP,
    S_CALL,
    S_JMP,
    S_SERVICE
  } state_t;

  localparam logic [1:0] CALL_LAST = 2'(CALL_CYCLES - 1);

  state_t          r_state;
  state_t          w_nextState;
  logic [NIRQ-1:0] r_prev;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] r_mask;
  logic [2:0]      r_idx;
  logic [1:0]      r_callCnt;
  logic [1:0]      w_callCntNext;
  logic [NIRQ-1:0] w_edge;
  logic [NIRQ-1:0] w_req;
  logic [NIRQ-1:0] w_clr;
  logic [2:0]      w_grantIdx;
  logic            w_grant;
  logic            w_accept;

  assign w_edge   = interrupts & ~r_prev;
  assign w_req    = r_pending & r_mask;
  assign w_accept = (r_state == S_IDLE) && w_grant;

  // Lowest enabled pending index wins; w_clr is its one-hot clear mask.
  always_comb begin
    w_grant    = 1'b0;
    w_grantIdx = 3'd0;
    w_clr      = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (w_req[i] && !w_grant) begin
        w_grant    = 1'b1;
        w_grantIdx = 3'(i);
        w_clr[i]   = 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_callCntNext = r_callCnt;
    Addr          = 16'h0000;
    Call          = 1'b0;
    INTjmp        = 1'b0;
    intSTOP       = 1'b0;
    active        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_nextState = S_STOP;
      end
      S_STOP: begin
        intSTOP       = 1'b1;
        w_callCntNext = 2'd0;
        w_nextState   = S_CALL;
      end
      S_CALL: begin
        intSTOP = 1'b1;
        Call    = 1'b1;
        if (r_callCnt == CALL_LAST) w_nextState = S_JMP;
        else w_callCntNext = r_callCnt + 2'd1;
      end
      S_JMP: begin
        intSTOP     = 1'b1;
        INTjmp      = 1'b1;
        Addr        = VEC_BASE + {13'b0, r_idx};
        w_nextState = S_SERVICE;
      end
      S_SERVICE: begin
        active = 1'b1;
        if (reti) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Edge-detect history resets to all ones so lines already high at release never fire.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_callCnt <= 2'd0;
      r_prev    <= '1;
      r_pending <= '0;
      r_mask    <= '0;
      r_idx     <= 3'd0;
    end else begin
      r_state   <= w_nextState;
      r_callCnt <= w_callCntNext;
      r_prev    <= interrupts;
      r_pending <= (r_pending & ~(w_accept ? w_clr : '0)) | w_edge;
      if (mask_we) r_mask <= mask_wdata;
      if (w_accept) r_idx <= w_grantIdx;
    end
  end

  assign irq_idx = r_idx;
  assign pending = r_pending;
  assign mask    = r_mask;

endmodule

// File: tb/tb_int_sequencer.sv
// Randomised and directed bench for int_sequencer, checked every cycle against a
// timeline-based reference model of the interrupt entry sequence.
module tb_int_sequencer;

  localparam int          NIRQ        = 8;
  localparam int          CALL_CYCLES = 2;
  localparam logic [15:0] VEC_BASE    = 16'h00F8;
  localparam int          JMP_POS     = CALL_CYCLES + 2;
  localparam int          SERVICE_POS = CALL_CYCLES + 3;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [NIRQ-1:0] interrupts = '0;
  logic            mask_we = 1'b0;
  logic [NIRQ-1:0] mask_wdata = '0;
  logic            reti = 1'b0;
  logic [15:0]     Addr;
  logic            Call;
  logic            INTjmp;
  logic            intSTOP;
  logic            active;
  logic [2:0]      irq_idx;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] mask;

  int numVectors     = 0;
  int numMiscompares = 0;

  // Reference model: mPos counts cycles into the entry timeline (0 = idle).
  logic [NIRQ-1:0] mPending;
  logic [NIRQ-1:0] mMask;
  logic [NIRQ-1:0] mPrev;
  int              mPos;
  int              mIdx;

  int          jmpCount;
  int          callCount;
  logic [15:0] lastJmpAddr;
  logic [NIRQ-1:0] lines;

  int_sequencer #(
    .NIRQ(NIRQ), .VEC_BASE(VEC_BASE), .CALL_CYCLES(CALL_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .interrupts(interrupts), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .reti(reti), .Addr(Addr), .Call(Call),
    .INTjmp(INTjmp), .intSTOP(intSTOP), .active(active), .irq_idx(irq_idx),
    .pending(pending), .mask(mask)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numVectors++;
    if (observed !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int lowestSet(input logic [NIRQ-1:0] v);
    for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic modelStep(input logic [NIRQ-1:0] irqs, input logic we,
                           input logic [NIRQ-1:0] wd, input logic ret, input logic rstN);
    logic [NIRQ-1:0] edges;
    if (!rstN) begin
      mPending = '0; mMask = '0; mPrev = '1; mPos = 0; mIdx = 0;
    end else begin
      edges = irqs & ~mPrev;
      mPrev = irqs;
      if (mPos == 0) begin
        if ((mPending & mMask) != 0) begin
          mIdx = lowestSet(mPending & mMask);
          mPending[mIdx] = 1'b0;
          mPos = 1;
        end
      end else if (mPos < SERVICE_POS) begin
        mPos++;
      end else if (ret) begin
        mPos = 0;
      end
      mPending = mPending | edges;
      if (we) mMask = wd;
    end
  endtask

  task automatic applyStimulus(input logic [NIRQ-1:0] irqs, input logic we,
                               input logic [NIRQ-1:0] wd, input logic ret, input logic rstN);
    logic [15:0] expAddr;
    @(negedge CLK);
    interrupts = irqs; mask_we = we; mask_wdata = wd; reti = ret; RST = rstN;
    @(posedge CLK);
    modelStep(irqs, we, wd, ret, rstN);
    #1;
    expAddr = (mPos == JMP_POS) ? VEC_BASE + 16'(mIdx) : 16'h0000;
    checkOutput("intSTOP", 32'(intSTOP), 32'(mPos >= 1 && mPos <= JMP_POS));
    checkOutput("Call", 32'(Call), 32'(mPos >= 2 && mPos <= CALL_CYCLES + 1));
    checkOutput("INTjmp", 32'(INTjmp), 32'(mPos == JMP_POS));
    checkOutput("Addr", 32'(Addr), 32'(expAddr));
    checkOutput("active", 32'(active), 32'(mPos == SERVICE_POS));
    checkOutput("irq_idx", 32'(irq_idx), 32'(mIdx));
    checkOutput("pending", 32'(pending), 32'(mPending));
    checkOutput("mask", 32'(mask), 32'(mMask));
    if (INTjmp) begin jmpCount++; lastJmpAddr = Addr; end
    if (Call) callCount++;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(lines, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic writeMask(input logic [NIRQ-1:0] m);
    applyStimulus(lines, 1'b1, m, 1'b0, 1'b1);
  endtask

  task automatic pulseReti();
    applyStimulus(lines, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    lines = '0; jmpCount = 0; callCount = 0; lastJmpAddr = '0;
    mPending = '0; mMask = '0; mPrev = '1; mPos = 0; mIdx = 0;

    applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("resetOutputs",
                {Addr, Call, INTjmp, intSTOP, active, 1'b0, irq_idx, pending},
                32'h0);

    // Single source on bit 2
    writeMask(8'h04);
    lines = 8'h04; idleCycles(1); lines = '0;
    checkOutput("singlePendSet", 32'(pending), 32'h04);
    jmpCount = 0; callCount = 0;
    idleCycles(6);
    checkOutput("singleAddr", 32'(lastJmpAddr), 32'h00FA);
    checkOutput("singleCallWidth", 32'(callCount), 32'd2);
    checkOutput("singleActive", 32'(active), 32'd1);
    checkOutput("singlePendClr", 32'(pending), 32'h0);
    pulseReti(); idleCycles(2);

    // Priority between bits 5 and 1
    writeMask(8'hFF);
    lines = 8'h22; idleCycles(1); lines = '0;
    idleCycles(6);
    checkOutput("prioFirst", 32'(lastJmpAddr), 32'h00F9);
    checkOutput("prioStillPending", 32'(pending), 32'h20);
    pulseReti();
    idleCycles(1);
    checkOutput("prioGapStop", 32'(intSTOP), 32'd1);
    idleCycles(5);
    checkOutput("prioSecond", 32'(lastJmpAddr), 32'h00FD);
    pulseReti(); idleCycles(2);

    // Masked source latches, fires after enable
    writeMask(8'h00);
    lines = 8'h80; idleCycles(1); lines = '0;
    idleCycles(3);
    checkOutput("maskedNoStop", 32'(intSTOP), 32'd0);
    checkOutput("maskedPend", 32'(pending), 32'h80);
    writeMask(8'h80);
    idleCycles(6);
    checkOutput("unmaskedAddr", 32'(lastJmpAddr), 32'h00FF);
    pulseReti(); idleCycles(2);

    // Level-held line fires once; re-edge during service waits for reti
    writeMask(8'h01);
    jmpCount = 0;
    lines = 8'h01; idleCycles(20);
    checkOutput("levelOnce", 32'(jmpCount), 32'd1);
    lines = 8'h00; idleCycles(1);
    lines = 8'h01; idleCycles(2);
    checkOutput("reEdgePend", 32'(pending[0]), 32'd1);
    idleCycles(4);
    checkOutput("noNesting", 32'(jmpCount), 32'd1);
    pulseReti(); idleCycles(7);
    checkOutput("secondEntry", 32'(jmpCount), 32'd2);
    lines = '0; pulseReti(); idleCycles(2);

    // Reset during CALL with lines held high across release
    writeMask(8'hFF);
    lines = 8'h08; idleCycles(1); lines = '0;
    idleCycles(2);
    checkOutput("inCall", 32'(Call), 32'd1);
    lines = 8'hFF;
    applyStimulus(lines, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("midResetOutputs",
                {Addr, Call, INTjmp, intSTOP, active, 1'b0, irq_idx, pending},
                32'h0);
    checkOutput("midResetMask", 32'(mask), 32'h0);
    writeMask(8'hFF);
    jmpCount = 0;
    idleCycles(8);
    checkOutput("heldNoFire", 32'(jmpCount), 32'd0);
    lines = '0; idleCycles(1);

    // Stray reti in IDLE and during CALL
    pulseReti();
    lines = 8'h08; idleCycles(1); lines = '0;
    callCount = 0; jmpCount = 0;
    idleCycles(2);
    pulseReti();
    idleCycles(3);
    checkOutput("strayCallWidth", 32'(callCount), 32'd2);
    checkOutput("strayJmp", 32'(jmpCount), 32'd1);
    checkOutput("strayAddr", 32'(lastJmpAddr), 32'h00FB);
    pulseReti(); idleCycles(2);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NIRQ-1:0] toggle;
      logic we, ret, rstN;
      logic [NIRQ-1:0] wd;
      toggle = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      lines  = lines ^ toggle;
      we     = ($urandom_range(0, 15) == 0);
      wd     = 8'($urandom);
      ret    = ($urandom_range(0, 5) == 0);
      rstN   = ($urandom_range(0, 299) != 0);
      applyStimulus(lines, we, wd, ret, rstN);
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Prioritised, maskable interrupt controller that sequences the CPU's interrupt entry: pipeline stall, return-address push (Call), then vector jump (INTjmp).
- Sits between the eight external interrupt lines and the control unit / PC logic.
- Holds off further entries until the handler signals return (reti).
- Entry outputs use the same Addr/Call/INTjmp/intSTOP contract as the existing interrupt stub.

Parameters:
- NIRQ, 8, number of interrupt sources (bit 0 = highest priority).
- VEC_BASE, 16'h00F8, vector address of source 0; source i vectors to VEC_BASE+i.
- CALL_CYCLES, 2, cycles Call is held high (stack push duration); legal range 1..3.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous, active-low reset.
- interrupts  input  NIRQ  raw interrupt request lines, rising-edge triggered, synchronous to CLK.
- mask_we  input  1  write strobe for the enable mask.
- mask_wdata  input  NIRQ  new mask value; bit=1 enables that source.
- reti  input  1  one-cycle pulse from the control unit on return-from-interrupt.
- Addr  output  16  vector address; valid only while INTjmp=1, else 0.
- Call  output  1  push PC request to the stack logic.
- INTjmp  output  1  load PC from Addr.
- intSTOP  output  1  freeze fetch/decode during the entry sequence.
- active  output  1  handler in service (entry done, awaiting reti).
- irq_idx  output  3  index of the accepted/in-service source.
- pending  output  NIRQ  latched pending bits (status readback).
- mask  output  NIRQ  current mask register.

Behaviour:
- Reset (RST=0 at a rising edge):
  - state=IDLE; pending=0; mask=0; irq_idx=0.
  - Edge-detect register = all ones, so lines held high through reset do not fire.
  - All outputs 0.
  - Reset wins over every other event, including mid-sequence; an in-flight entry is abandoned with no partial pulses afterwards.
- Edge detect:
  - pending[i] sets on the cycle after interrupts[i] is sampled 1 with its previous sample 0.
  - Level-held lines fire once.
- Masking:
  - mask_we writes mask next edge.
  - Masked sources still latch pending and fire once unmasked.
  - Mask changes never affect an already-captured irq_idx.
- Arbitration (IDLE only):
  - If (pending & mask)!=0, capture the lowest set index into irq_idx, clear that pending bit, go to STOP.
  - If a new edge on the same bit coincides with its clear, set wins and the pending bit stays 1.
- States (outputs decoded from registered state, Moore):
  - IDLE: all outputs 0.
  - STOP: intSTOP=1, 1 cycle, drains the pipeline; then CALL.
  - CALL: intSTOP=1, Call=1 for exactly CALL_CYCLES cycles (2-bit counter); then JMP.
  - JMP: intSTOP=1, INTjmp=1, Addr=VEC_BASE+irq_idx (16-bit add, no overflow at default), 1 cycle; then SERVICE.
  - SERVICE: active=1, other controls 0.
    - reti → IDLE next edge; arbitration resumes in IDLE the following cycle.
    - No nesting: new requests only accumulate in pending.
- reti outside SERVICE is ignored.
- Call and INTjmp are never high in the same cycle.
- Latency, interrupt edge first sampled at edge k with mask enabled and state IDLE:
  - pending set after k.
  - STOP after k+1.
  - Call high after k+2 and k+3 (default).
  - INTjmp after k+4.
  - active after k+5.
  - Minimum gap between reti and the next STOP is 2 edges.

Test Plan:
- Single source: mask=8'h04, pulse interrupts[2] → pending=8'h04 next cycle; intSTOP 1 cycle; Call high 2 cycles; INTjmp 1 cycle with Addr=16'h00FA; then active=1, pending=0.
- Priority: mask=8'hFF, raise bits 5 and 1 on the same edge → bit 1 taken first (Addr=16'h00F9). Pulse reti → bit 5 taken next (Addr=16'h00FD) after 2 edges.
- Masked then enabled: mask=0, pulse bit 7 → pending=8'h80, no intSTOP. Write mask=8'h80 → entry with Addr=16'h00FF.
- Level held / re-edge: hold interrupts[0] high for 20 cycles → exactly one entry. Drop and re-raise it during SERVICE → pending[0]=1 and a second entry only after reti.
- Reset mid-sequence: assert RST=0 during CALL → next edge all outputs 0, state IDLE, pending=0, mask=0. Lines held high across reset release do not fire.
- Stray reti in IDLE and CALL → no state change; the sequence completes with normal Call/INTjmp pulse widths.
